// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem: AHB-Lite memory slave with wait states, byte-lane writes and RAW forwarding.
// Define AHB_SLV_ERR_RESP_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_lite_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready_in,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hready_out,
    output logic                  Hresp
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t                state, nxt;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] a_addr, r_addr;
    logic [2:0]            a_size;
    logic                  a_write, a_bad;
    logic                  acc, bus_bad, from_bus, r_bad, ld, wr;
    logic [NB-1:0]         wmask;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  unused;

    function automatic logic illegal(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz);
        return (a >> LB) >= ADDR_WIDTH'(MEM_DEPTH) || int'(sz) > LB
            || (a[LB-1:0] & ((LB'(1) << sz) - LB'(1))) != '0;
    endfunction

    assign unused   = ^{Hburst, Htrans[0]};
    assign acc      = Hsel && Hready_in && Htrans[1] && Hready_out;
    assign bus_bad  = illegal(Haddr, Hsize);
    // Outside WAIT the read word is fetched straight from the address bus in the accept cycle
    assign from_bus = state != WAIT;
    assign r_addr   = from_bus ? Haddr : a_addr;
    assign r_bad    = from_bus ? bus_bad : a_bad;
    assign ld       = nxt == DATA && !(from_bus ? Hwrite : a_write);
    assign wr       = state == DATA && a_write && !a_bad;

    always_comb
        nxt = state == WAIT ? (cnt == 4'(WAIT_STATES - 1) ? DATA : WAIT)
            : state == ERR1 ? ERR2
            : acc ? ((ERR_EN && bus_bad) ? ERR1 : (WAIT_STATES > 0) ? WAIT : DATA)
            : IDLE;

    always_comb
        for (int i = 0; i < NB; i++)
            wmask[i] = i >= int'(a_addr[LB-1:0]) && i < int'(a_addr[LB-1:0]) + (1 << a_size);

    // Merge lanes being written this cycle so a back-to-back read never sees stale data
    always_comb begin
        rword = mem[r_addr[LB +: IW]];
        for (int i = 0; i < NB; i++)
            if (wr && wmask[i] && a_addr[LB +: IW] == r_addr[LB +: IW])
                rword[i*8 +: 8] = Hwdata[i*8 +: 8];
    end

    always_ff @(posedge hclk or posedge hreset)
        if (hreset) begin
            state      <= IDLE;
            cnt        <= '0;
            Hready_out <= 1'b1;
            Hresp      <= 1'b0;
            Hrdata     <= '0;
            a_addr     <= '0;
            a_size     <= '0;
            a_write    <= 1'b0;
            a_bad      <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= state == WAIT ? cnt + 1'b1 : '0;
            Hready_out <= !(nxt == WAIT || nxt == ERR1);
            Hresp      <= nxt == ERR1 || nxt == ERR2;
            if (acc) begin
                a_addr  <= Haddr;
                a_size  <= Hsize;
                a_write <= Hwrite;
                a_bad   <= bus_bad;
            end
            if (ld)
                Hrdata <= r_bad ? '0 : rword;
        end

    always_ff @(posedge hclk)
        if (wr)
            for (int i = 0; i < NB; i++)
                if (wmask[i])
                    mem[a_addr[LB +: IW]][i*8 +: 8] <= Hwdata[i*8 +: 8];
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb_ahb_lite_slave_mem: directed and random AHB-Lite traffic on three wait-state configurations,
// checked against a byte-array model; AHB_SLV_ERR_RESP_EN selects the expected error behaviour.
module tb_ahb_lite_slave_mem;
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        bad;
    } xfer_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        hsel = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0, hburst = '0;
    logic [31:0] rd0, rd1, rd2, rd;
    logic        rdy0, rdy1, rdy2, rsp0, rsp1, rsp2, rdy, rsp;
    int          cur = 0;
    int          checks = 0, errors = 0;
    int          ws_tab [3] = '{0, 2, 3};
    logic [7:0]  mdl [3][256];
    xfer_t       pend = '0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    assign rd  = cur == 0 ? rd0 : cur == 1 ? rd1 : rd2;
    assign rdy = cur == 0 ? rdy0 : cur == 1 ? rdy1 : rdy2;
    assign rsp = cur == 0 ? rsp0 : cur == 1 ? rsp1 : rsp2;

    ahb_lite_slave_mem #(.WAIT_STATES(0)) u0 (
        .hclk(clk), .hreset(rst), .Hsel(hsel && cur == 0), .Haddr(haddr), .Htrans(htrans),
        .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hwdata(hwdata), .Hready_in(rdy0),
        .Hrdata(rd0), .Hready_out(rdy0), .Hresp(rsp0));
    ahb_lite_slave_mem #(.WAIT_STATES(2)) u1 (
        .hclk(clk), .hreset(rst), .Hsel(hsel && cur == 1), .Haddr(haddr), .Htrans(htrans),
        .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hwdata(hwdata), .Hready_in(rdy1),
        .Hrdata(rd1), .Hready_out(rdy1), .Hresp(rsp1));
    ahb_lite_slave_mem #(.WAIT_STATES(3)) u2 (
        .hclk(clk), .hreset(rst), .Hsel(hsel && cur == 2), .Haddr(haddr), .Htrans(htrans),
        .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hwdata(hwdata), .Hready_in(rdy2),
        .Hrdata(rd2), .Hready_out(rdy2), .Hresp(rsp2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%h expected=%h", tag, cur, obs, exp);
        end
    endtask

    function automatic logic bad_of(input logic [31:0] a, input logic [2:0] sz);
        return a / 4 >= 1024 || sz > 2 || a % (32'd1 << sz) != 0;
    endfunction

    function automatic logic [31:0] mword(input int k, input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[i*8 +: 8] = mdl[k][int'(a[7:2]) * 4 + i];
        return w;
    endfunction

    function automatic void mwrite(input int k, input logic [31:0] a, input logic [2:0] sz,
                                   input logic [31:0] wd);
        for (int j = 0; j < (1 << sz); j++)
            mdl[k][int'(a[7:0]) + j] = wd[(int'(a[1:0]) + j) * 8 +: 8];
    endfunction

    // One address phase; completes (and checks) the previous transfer's data phase alongside it
    task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic w, input logic [2:0] sz, input logic [31:0] wd);
        int   waits;
        logic wresp, exp_err;
        waits = 0;
        wresp = 1'b0;
        hsel = sel; htrans = tr; haddr = a; hwrite = w; hsize = sz; hwdata = pend.wd;
        #1;
        while (!rdy && waits < 40) begin
            wresp |= rsp;
            waits++;
            @(posedge clk);
            @(negedge clk);
        end
        if (pend.v) begin
            exp_err = ERR_EN && pend.bad;
            chk("waits", 32'(waits), exp_err ? 32'd1 : 32'(ws_tab[cur]));
            chk("wait_resp", 32'(wresp), 32'(exp_err));
            chk("resp", 32'(rsp), 32'(exp_err));
            if (!pend.w && !exp_err) begin
                chk("rdata", rd, pend.bad ? 32'd0 : mword(cur, pend.a));
                last_rd = rd;
            end
            if (pend.w && !pend.bad)
                mwrite(cur, pend.a, pend.sz, pend.wd);
        end else begin
            chk("idle_waits", 32'(waits), 32'd0);
            chk("idle_resp", 32'(rsp), 32'd0);
        end
        @(posedge clk);
        pend = '{v: sel && tr[1], w: w, a: a, sz: sz, wd: wd, bad: bad_of(a, sz)};
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic fill(input int k);
        cur = k;
        for (int a = 0; a < 256; a += 4)
            step(1'b1, 2'b10, 32'(a), 1'b1, 3'd2, $urandom | 32'h1);
        idle();
    endtask

    task automatic random_ops(input int k, input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        cur = k;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 11);
            sz = 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
            if (r == 0) a = 32'h1000 + (a & 32'hFC);
            if (r == 1) begin sz = 3'd2; a = a | 32'h1; end
            if (r == 2) sz = 3'd3;
            step(r != 3, r == 4 ? 2'b00 : r == 5 ? 2'b01 : {1'b1, 1'($urandom_range(0, 1))},
                 a, 1'($urandom_range(0, 1)), sz, $urandom);
        end
        idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cur = k;
            #1;
            chk("rst_ready", 32'(rdy), 32'd1);
            chk("rst_resp", 32'(rsp), 32'd0);
            chk("rst_rdata", rd, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) fill(k);

        // WS=0: write then immediate read of the same word relies on forwarding
        cur = 0;
        step(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        step(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
        idle();
        chk("fwd", last_rd, 32'hDEADBEEF);
        step(1'b1, 2'b10, 32'h30, 1'b1, 3'd2, 32'h11223344);
        step(1'b1, 2'b10, 32'h31, 1'b1, 3'd0, 32'h0000AB00);
        step(1'b1, 2'b10, 32'h30, 1'b0, 3'd2, 32'h0);
        idle();
        chk("byte_lane", last_rd, 32'h1122AB44);
        step(1'b1, 2'b10, 32'h1000, 1'b1, 3'd2, 32'h12345678);
        step(1'b1, 2'b10, 32'h1000, 1'b0, 3'd2, 32'h0);
        step(1'b1, 2'b10, 32'h42, 1'b1, 3'd2, 32'hFFFFFFFF);
        step(1'b1, 2'b10, 32'h44, 1'b1, 3'd3, 32'hFFFFFFFF);
        step(1'b1, 2'b10, 32'h0, 1'b0, 3'd2, 32'h0);
        step(1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'h0);
        idle();
        hburst = 3'b011;
        step(1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 32'hA0A0A0A0);
        step(1'b1, 2'b11, 32'h44, 1'b1, 3'd2, 32'hA1A1A1A1);
        step(1'b1, 2'b01, 32'h48, 1'b1, 3'd2, 32'h0);
        step(1'b1, 2'b11, 32'h48, 1'b1, 3'd2, 32'hA2A2A2A2);
        step(1'b1, 2'b11, 32'h4C, 1'b1, 3'd2, 32'hA3A3A3A3);
        hburst = 3'b000;
        for (int a = 'h40; a <= 'h4C; a += 4)
            step(1'b1, 2'b10, 32'(a), 1'b0, 3'd2, 32'h0);
        idle();
        chk("burst_last", last_rd, 32'hA3A3A3A3);

        // WS=2: plain read of word 8
        cur = 1;
        step(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
        idle();

        // WS=3: reset during a pending write's wait states
        cur = 2;
        step(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
        step(1'b1, 2'b10, 32'h50, 1'b1, 3'd2, 32'hCAFEF00D);
        chk("in_wait", 32'(rdy), 32'd0);
        chk("rd_before_rst", rd, mword(2, 32'h20));
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(rdy), 32'd1);
        chk("mid_rst_resp", 32'(rsp), 32'd0);
        chk("mid_rst_rdata", rd, 32'd0);
        hsel = 1'b0;
        htrans = 2'b00;
        pend = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2'b10, 32'h50, 1'b0, 3'd2, 32'h0);
        idle();

        for (int k = 0; k < 3; k++) random_ops(k, 120);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
